// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, owner id and
// the error pair returned to a master with its acknowledge.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic access_fault;
    logic addr_misaligned;
  } arb_err_t;

  // Wide enough for the largest legal LATENCY (4)
  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the two masters.
// Contention policy: round robin when ARB_ROUND_ROBIN_EN is defined, otherwise m0 wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  owner_e     last_owner,
  output owner_e     owner
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWNER_M1);
`endif

  always_comb begin
    owner = OWNER_M0;
    if (reqs == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      owner = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
`else
      owner = OWNER_M0;
`endif
    end else if (reqs[1]) begin
      owner = OWNER_M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single mmu port; one transaction in flight.
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of fixed m0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_unit,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  output logic [1:0]  m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_unit,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic [1:0]  m1_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  mem_rd_unit,
  output logic [1:0]  mem_wd_unit,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        access_fault,
  input  logic        addr_misaligned
);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, last_owner_q, pick_owner;
  logic             we_q;
  logic [1:0]       unit_q;
  logic [31:0]      addr_q, wd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant, first_busy, fault_now, done;
  arb_err_t         fault_bits, rsp_err;
  logic [31:0]      rsp_rd;

  mem_arb_pick u_pick (
    .reqs       ({m1_req, m0_req}),
    .last_owner (last_owner_q),
    .owner      (pick_owner)
  );

  assign grant      = (state_q == IDLE) && (m0_req || m1_req);
  assign fault_bits = {access_fault, addr_misaligned};
  assign first_busy = (state_q == BUSY) && (cnt_q == CNT_W'(LATENCY));
  // A fault reported on the first busy cycle cuts the transaction short
  assign fault_now  = first_busy && (fault_bits != 2'b00);
  assign done       = (state_q == BUSY) && ((cnt_q == CNT_W'(1)) || fault_now);
  assign rsp_rd     = (fault_now || we_q) ? 32'h0 : mem_rd;
  assign rsp_err    = fault_now ? fault_bits : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_rd_unit = 2'b00;
    mem_wd_unit = 2'b00;
    mem_addr    = 32'h0;
    mem_wd      = 32'h0;
    case (state_q)
      IDLE: if (grant) state_d = BUSY;
      BUSY: begin
        if (done) state_d = IDLE;
        mem_re      = ~we_q;
        mem_we      = we_q && first_busy;
        mem_rd_unit = unit_q;
        mem_wd_unit = unit_q;
        mem_addr    = addr_q;
        mem_wd      = wd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      owner_q      <= OWNER_M0;
      last_owner_q <= OWNER_M1;
      we_q         <= 1'b0;
      unit_q       <= 2'b00;
      addr_q       <= 32'h0;
      wd_q         <= 32'h0;
    end else if (grant) begin
      owner_q      <= pick_owner;
      last_owner_q <= pick_owner;
      cnt_q        <= CNT_W'(LATENCY);
      if (pick_owner == OWNER_M1) begin
        we_q <= m1_we; unit_q <= m1_unit; addr_q <= m1_addr; wd_q <= m1_wd;
      end else begin
        we_q <= m0_we; unit_q <= m0_unit; addr_q <= m0_addr; wd_q <= m0_wd;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= done ? '0 : cnt_q - CNT_W'(1);
    end
  end

  // Responses are single-cycle pulses; data and error are zero outside the ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_ack <= 1'b0; m0_rd <= 32'h0; m0_err <= 2'b00;
      m1_ack <= 1'b0; m1_rd <= 32'h0; m1_err <= 2'b00;
    end else begin
      m0_ack <= 1'b0; m0_rd <= 32'h0; m0_err <= 2'b00;
      m1_ack <= 1'b0; m1_rd <= 32'h0; m1_err <= 2'b00;
      if (done) begin
        if (owner_q == OWNER_M1) begin
          m1_ack <= 1'b1; m1_rd <= rsp_rd; m1_err <= rsp_err;
        end else begin
          m0_ack <= 1'b1; m0_rd <= rsp_rd; m0_err <= rsp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases followed by random
// back-to-back traffic compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_unit, m1_unit;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic [1:0]  m0_err, m1_err;
  logic        mem_re, mem_we;
  logic [1:0]  mem_rd_unit, mem_wd_unit;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        access_fault, addr_misaligned;

  int checks = 0;
  int fails  = 0;
  bit last_owner_m = 1'b1;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_unit(m0_unit), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_ack(m0_ack), .m0_rd(m0_rd), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_unit(m1_unit), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_ack(m1_ack), .m1_rd(m1_rd), .m1_err(m1_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rd_unit(mem_rd_unit), .mem_wd_unit(mem_wd_unit),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .access_fault(access_fault), .addr_misaligned(addr_misaligned)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Who should win given the current requests and the previous grant
  function automatic bit modelPick(input bit r0, input bit r1, input bit last);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last;
`else
      return 1'b0;
`endif
    end
    return r1;
  endfunction

  task automatic newRequest(input bit idx);
    if (idx) begin
      m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1)); m1_unit = 2'($urandom_range(0, 3));
      m1_addr = $urandom; m1_wd = $urandom;
    end else begin
      m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1)); m0_unit = 2'($urandom_range(0, 3));
      m0_addr = $urandom; m0_wd = $urandom;
    end
  endtask

  task automatic raiseRandom();
    if (!m0_req && $urandom_range(0, 1) == 1) newRequest(1'b0);
    if (!m1_req && $urandom_range(0, 1) == 1) newRequest(1'b1);
    if (!m0_req && !m1_req) newRequest(1'($urandom_range(0, 1)));
  endtask

  // Called at a negedge in IDLE with at least one request high; runs one transaction
  task automatic applyStimulus(input logic [1:0] fault);
    bit          w;
    logic        we_w;
    logic [1:0]  unit_w;
    logic [31:0] addr_w, wd_w, rd_exp;
    int          done;
    w      = modelPick(m0_req, m1_req, last_owner_m);
    we_w   = w ? m1_we   : m0_we;
    unit_w = w ? m1_unit : m0_unit;
    addr_w = w ? m1_addr : m0_addr;
    wd_w   = w ? m1_wd   : m0_wd;
    last_owner_m = w;
    done   = (fault != 2'b00) ? 2 : LAT + 1;
    rd_exp = (fault != 2'b00 || we_w) ? 32'h0 : mem_rd;
    for (int c = 1; c <= done; c++) begin
      @(negedge clk);
      if (c < done) begin
        checkOutput("busy_mem_re", 32'(mem_re), 32'(!we_w));
        checkOutput("busy_mem_we", 32'(mem_we), 32'((c == 1) && we_w));
        checkOutput("busy_mem_addr", mem_addr, addr_w);
        checkOutput("busy_mem_wd", mem_wd, wd_w);
        checkOutput("busy_units", 32'({mem_rd_unit, mem_wd_unit}), 32'({unit_w, unit_w}));
        checkOutput("busy_no_ack", 32'({m1_ack, m0_ack}), 32'h0);
        {access_fault, addr_misaligned} = (c == 1) ? fault : 2'b00;
      end else begin
        {access_fault, addr_misaligned} = 2'b00;
        checkOutput("ack", 32'({m1_ack, m0_ack}), w ? 32'h2 : 32'h1);
        checkOutput("owner_rd", w ? m1_rd : m0_rd, rd_exp);
        checkOutput("owner_err", 32'(w ? m1_err : m0_err), 32'(fault));
        checkOutput("other_rd_err", w ? (m0_rd | 32'(m0_err)) : (m1_rd | 32'(m1_err)), 32'h0);
        checkOutput("idle_mem", 32'({mem_re, mem_we, mem_rd_unit, mem_wd_unit}) | mem_addr, 32'h0);
        if (w) m1_req = 1'b0; else m0_req = 1'b0;
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_unit = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_unit = 0; m1_addr = 0; m1_wd = 0;
    mem_rd = 0; access_fault = 0; addr_misaligned = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
    checkOutput("rst_rd", m0_rd | m1_rd, 32'h0);
    checkOutput("rst_err", 32'({m0_err, m1_err}), 32'h0);
    checkOutput("rst_mem", 32'({mem_re, mem_we, mem_rd_unit, mem_wd_unit}) | mem_addr | mem_wd, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    m0_req = 1; m0_we = 0; m0_unit = 2'd2; m0_addr = 32'h4000_0010; m0_wd = 0;
    mem_rd = 32'hDEAD_BEEF;
    applyStimulus(2'b00);

    m1_req = 1; m1_we = 1; m1_unit = 2'd0; m1_addr = 32'hA000_0000; m1_wd = 32'h5A;
    mem_rd = 32'h1234_5678;
    applyStimulus(2'b00);

    m0_req = 1; m0_we = 0; m0_unit = 2'd2; m0_addr = 32'h0;
    applyStimulus(2'b10);

    // Reset during the second busy cycle drops the transaction silently
    m1_req = 1; m1_we = 0; m1_unit = 2'd1; m1_addr = 32'h0000_0100;
    @(negedge clk);
    checkOutput("pre_rst_busy1", 32'(mem_re), 32'h1);
    @(negedge clk);
    checkOutput("pre_rst_busy2", 32'(mem_re), 32'h1);
    reset = 1'b1; m1_req = 1'b0;
    #1;
    checkOutput("mid_rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
    checkOutput("mid_rst_mem", 32'({mem_re, mem_we, mem_rd_unit, mem_wd_unit}) | mem_addr | mem_wd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_owner_m = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_rst_no_ack", 32'({m1_ack, m0_ack}), 32'h0);
    end

    // Repeated contention: the loser keeps requesting, the winner re-requests
    newRequest(1'b0); newRequest(1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b00);
      if (!m0_req) newRequest(1'b0);
      if (!m1_req) newRequest(1'b1);
    end
    for (int i = 0; i < 2; i++) if (m0_req || m1_req) applyStimulus(2'b00);

    for (int i = 0; i < 200; i++) begin
      raiseRandom();
      mem_rd = $urandom;
      applyStimulus(($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
